// File: rtl/board_pkg.sv
// Board-wide constants shared by the button/LED blocks, plus the debounce event
// encoding and counter sizing helper.
package board_pkg;

  localparam int unsigned CLK_HZ                  = 100_000_000;
  localparam int unsigned DEBOUNCE_MS_DEFAULT     = 10;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS_DEFAULT;

  typedef enum logic [1:0] {
    EV_NONE    = 2'b00,
    EV_PRESS   = 2'b01,
    EV_RELEASE = 2'b10
  } edge_ev_t;

  // $clog2(cycles) bits always hold cycles-1; keep at least one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, saturating agreement counter and
// registered press/release strobes.
module debounce_channel
  import board_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  edge_ev_t      r_ev;

  logic w_cur;
  logic w_differ;
  logic w_accept;

  assign w_cur    = r_sync2 ^ ACTIVE_LOW;
  assign w_differ = (w_cur != r_stable);
  assign w_accept = w_differ && (r_cnt == CNT_LAST);

  // Synchroniser resets to the released pin level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= ACTIVE_LOW;
      r_sync2 <= ACTIVE_LOW;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_ev     <= EV_NONE;
    end else begin
      r_ev <= EV_NONE;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_stable <= w_cur;
        r_cnt    <= '0;
        r_ev     <= w_cur ? EV_PRESS : EV_RELEASE;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign level = r_stable;
  assign rise  = (r_ev == EV_PRESS);
  assign fall  = (r_ev == EV_RELEASE);

endmodule

// File: rtl/button_debounce.sv
// Debounces N raw push-button pins into clean held levels and one-cycle
// press/release strobes; channels are fully independent.
module button_debounce
  import board_pkg::*;
#(
  parameter int unsigned N_BUTTONS       = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BUTTONS-1:0] buttons,
  output logic [N_BUTTONS-1:0] pressed,
  output logic [N_BUTTONS-1:0] press_pulse,
  output logic [N_BUTTONS-1:0] release_pulse
);

  genvar gi;
  generate
    for (gi = 0; gi < N_BUTTONS; gi++) begin : g_ch
      debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .ACTIVE_LOW     (ACTIVE_LOW)
      ) u_ch (
        .clk  (clk),
        .rst  (rst),
        .raw  (buttons[gi]),
        .level(pressed[gi]),
        .rise (press_pulse[gi]),
        .fall (release_pulse[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed vector table, hand-written corner
// sequences and random pin activity checked against a sliding-window model.
module tb_button_debounce;

  localparam int D = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] buttons = 2'b11;
  logic [1:0] pressed;
  logic [1:0] press_pulse;
  logic [1:0] release_pulse;

  int n_cmp  = 0;
  int n_fail = 0;
  bit model_on = 1'b0;

  button_debounce #(
    .N_BUTTONS      (2),
    .DEBOUNCE_CYCLES(D),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .buttons      (buttons),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [1:0] ep, input logic [1:0] epp,
                     input logic [1:0] erp);
    n_cmp++;
    if (pressed !== ep || press_pulse !== epp || release_pulse !== erp) begin
      n_fail++;
      $display("FAIL %s: got pressed=%b press=%b release=%b, want pressed=%b press=%b release=%b",
               name, pressed, press_pulse, release_pulse, ep, epp, erp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, exp);
    end
  endtask

  // Reference model: a change is accepted on the edge where the last D values the
  // debouncer has seen (pin levels from two edges earlier) all disagree with the
  // reported level.
  logic [1:0] m_pressed = 2'b00;
  logic [1:0] m_pp      = 2'b00;
  logic [1:0] m_rp      = 2'b00;
  bit         dl  [2][2];
  bit         win [2][D];
  int         filled [2];

  initial forever begin
    @(posedge clk or negedge rst);
    if (rst !== 1'b1) begin
      m_pressed = 2'b00;
      m_pp      = 2'b00;
      m_rp      = 2'b00;
      for (int ch = 0; ch < 2; ch++) begin
        dl[ch][0]  = 1'b0;
        dl[ch][1]  = 1'b0;
        filled[ch] = 0;
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        bit cur;
        bit all_diff;
        cur       = dl[ch][1];
        dl[ch][1] = dl[ch][0];
        dl[ch][0] = ~buttons[ch];
        for (int k = D - 1; k > 0; k--) win[ch][k] = win[ch][k-1];
        win[ch][0] = cur;
        if (filled[ch] < D) filled[ch]++;
        all_diff = (filled[ch] == D);
        for (int k = 0; k < D; k++) if (win[ch][k] == m_pressed[ch]) all_diff = 1'b0;
        m_pp[ch] = 1'b0;
        m_rp[ch] = 1'b0;
        if (all_diff) begin
          m_pressed[ch] = cur;
          m_pp[ch]      = cur;
          m_rp[ch]      = ~cur;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (model_on) begin
      n_cmp++;
      if ({pressed, press_pulse, release_pulse} !== {m_pressed, m_pp, m_rp}) begin
        n_fail++;
        $display("FAIL model @%0t: got pressed=%b press=%b release=%b, want pressed=%b press=%b release=%b",
                 $time, pressed, press_pulse, release_pulse, m_pressed, m_pp, m_rp);
      end
    end
  end

  typedef struct {
    string      name;
    logic [1:0] btn;
    int         cyc;
    logic [1:0] ep;
    logic [1:0] epp;
    logic [1:0] erp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int bad;
    int npulse;
    int at;
    int hold[2];

    tbl.push_back('{"idle",         2'b11,  5, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{"p0_early",     2'b10, 17, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{"p0_strobe",    2'b10,  1, 2'b01, 2'b01, 2'b00});
    tbl.push_back('{"p0_held",      2'b10,  1, 2'b01, 2'b00, 2'b00});
    tbl.push_back('{"r0_early",     2'b11, 17, 2'b01, 2'b00, 2'b00});
    tbl.push_back('{"r0_strobe",    2'b11,  1, 2'b00, 2'b00, 2'b01});
    tbl.push_back('{"r0_done",      2'b11,  1, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{"both_early",   2'b00, 17, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{"both_strobe",  2'b00,  1, 2'b11, 2'b11, 2'b00});
    tbl.push_back('{"both_held",    2'b00,  1, 2'b11, 2'b00, 2'b00});
    tbl.push_back('{"r1_early",     2'b10, 17, 2'b11, 2'b00, 2'b00});
    tbl.push_back('{"r1_strobe",    2'b10,  1, 2'b01, 2'b00, 2'b10});
    tbl.push_back('{"r1_done",      2'b10,  1, 2'b01, 2'b00, 2'b00});
    tbl.push_back('{"r0b_strobe",   2'b11, 18, 2'b00, 2'b00, 2'b01});
    tbl.push_back('{"r0b_done",     2'b11,  1, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{"min16_wait",   2'b10, 16, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{"min16_strobe", 2'b11,  2, 2'b01, 2'b01, 2'b00});
    tbl.push_back('{"min16_held",   2'b11,  1, 2'b01, 2'b00, 2'b00});
    tbl.push_back('{"min16_rel",    2'b11, 15, 2'b00, 2'b00, 2'b01});
    tbl.push_back('{"min16_done",   2'b11,  1, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{"glitch15",     2'b10, 15, 2'b00, 2'b00, 2'b00});
    tbl.push_back('{"glitch_after", 2'b11, 30, 2'b00, 2'b00, 2'b00});

    // Reset held with both pins released, then 100 quiet cycles.
    rst     = 1'b0;
    buttons = 2'b11;
    repeat (5) @(negedge clk);
    model_on = 1'b1;
    chk("reset_hold", 2'b00, 2'b00, 2'b00);
    #2 rst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("reset_idle", 2'b00, 2'b00, 2'b00);
    end
    $display("reset: 100 idle cycles after release checked");

    for (int v = 0; v < tbl.size(); v++) begin
      buttons = tbl[v].btn;
      repeat (tbl[v].cyc) @(negedge clk);
      $display("vec %0d %s: buttons=%b after %0d cycles -> pressed=%b press=%b release=%b",
               v, tbl[v].name, tbl[v].btn, tbl[v].cyc, pressed, press_pulse, release_pulse);
      chk(tbl[v].name, tbl[v].ep, tbl[v].epp, tbl[v].erp);
    end

    // Bounce: toggle every 5 cycles for 100 cycles, then settle pressed.
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      buttons[0] = (k % 2 == 0) ? 1'b0 : 1'b1;
      repeat (5) begin
        @(negedge clk);
        if (pressed != 2'b00 || press_pulse != 2'b00 || release_pulse != 2'b00) bad++;
      end
    end
    chk_int("bounce_quiet", bad, 0);
    buttons[0] = 1'b0;
    npulse = 0;
    at     = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (press_pulse[0]) begin
        npulse++;
        at = i;
      end
    end
    $display("bounce: settle produced %0d press strobes, last at cycle %0d", npulse, at);
    chk_int("bounce_count", npulse, 1);
    chk_int("bounce_latency", at, D + 2);
    buttons = 2'b11;
    repeat (30) @(negedge clk);
    chk("bounce_released", 2'b00, 2'b00, 2'b00);

    // Reset mid-count: button1 already accepted, button0 counting at 10.
    buttons = 2'b01;
    repeat (19) @(negedge clk);
    chk("pre_rst_b1", 2'b10, 2'b00, 2'b00);
    buttons = 2'b00;
    repeat (12) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    $display("reset asserted mid-count: pressed=%b press=%b release=%b", pressed, press_pulse, release_pulse);
    chk("rst_async", 2'b00, 2'b00, 2'b00);
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (D + 1) @(negedge clk);
    chk("post_rst_early", 2'b00, 2'b00, 2'b00);
    @(negedge clk);
    chk("post_rst_strobe", 2'b11, 2'b11, 2'b00);
    @(negedge clk);
    chk("post_rst_held", 2'b11, 2'b00, 2'b00);

    // Random pin activity with occasional short asynchronous resets.
    buttons = 2'b11;
    repeat (30) @(negedge clk);
    hold[0] = $urandom_range(1, 30);
    hold[1] = $urandom_range(1, 30);
    for (int c = 0; c < 3000; c++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (hold[ch] == 0) begin
          buttons[ch] = ~buttons[ch];
          hold[ch]    = $urandom_range(1, 30);
        end
        hold[ch]--;
      end
      if ($urandom_range(0, 499) == 0) begin
        #1 rst = 1'b0;
        #2 rst = 1'b1;
      end
      @(negedge clk);
    end
    buttons = 2'b11;
    repeat (40) @(negedge clk);
    $display("random: 3000 cycles of pin activity compared against model");
    chk("final_idle", 2'b00, 2'b00, 2'b00);

    model_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
# button_debounce

Synchronises and debounces the raw push-button inputs (`BUT[1:0]` on the board) before they reach the button/LED logic. Each channel gets a two-flop synchroniser and a saturating agreement counter. The block produces a clean active-high level per button plus one-cycle press and release strobes. It sits between the `chip` top-level pins and the `button` consumer and runs on the 100 MHz board clock.

## Interface

Parameters:
- `N_BUTTONS`, default 2: number of independent channels.
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive agreeing cycles required to accept a change (10 ms at 100 MHz). Must be ≥ 2.
- `ACTIVE_LOW`, default 1: 1 means a raw pin reads 0 when the button is pressed.

Ports:
- `clk`, input, 1: 100 MHz system clock.
- `rst`, input, 1: reset, asynchronous, active-low.
- `buttons`, input, `N_BUTTONS`: raw asynchronous pin levels.
- `pressed`, output, `N_BUTTONS`: debounced level, 1 means held.
- `press_pulse`, output, `N_BUTTONS`: one-cycle strobe on an accepted press.
- `release_pulse`, output, `N_BUTTONS`: one-cycle strobe on an accepted release.

## Operation

- Per channel, `buttons[i]` passes through two flops (`sync1`, `sync2`). Polarity is normalised after `sync2`: `cur = sync2 ^ ACTIVE_LOW`, so `cur` is 1 when pressed.
- State per channel: `stable` (drives `pressed`) and `cnt`, width `$clog2(DEBOUNCE_CYCLES)`.
- When `cur == stable`: `cnt` is set to 0. Any disagreement that ends before acceptance is discarded, not resumed.
- When `cur != stable` and `cnt < DEBOUNCE_CYCLES-1`: `cnt` increments.
- When `cur != stable` and `cnt == DEBOUNCE_CYCLES-1`: on the next edge `stable` takes `cur` and `cnt` is set to 0. On that same edge, `press_pulse[i]` (0→1) or `release_pulse[i]` (1→0) is registered high for exactly one cycle.
- `cnt` never wraps; it is bounded by the accept condition.
- Channels are fully independent. Simultaneous accepts on several channels assert their strobes in the same cycle.
- `press_pulse[i]` and `release_pulse[i]` are never high together. A strobe never occurs without a matching change of `pressed[i]` in the same cycle.
- Reset (`rst` low, asynchronous):
  - `sync1` and `sync2` go to the released raw level (`ACTIVE_LOW`).
  - `stable`, `cnt`, `pressed`, `press_pulse` and `release_pulse` go to 0.
- Reset mid-count discards progress. After `rst` rises, a held button must satisfy the full latency again.
- A button held through reset release is reported as a press after the full latency.

## Timing

- All outputs are registered, with no combinational path from `buttons`.
- Latency from the `clk` edge that first samples a new, steady raw level to `pressed` or a strobe changing: 2 + `DEBOUNCE_CYCLES` cycles.
- Minimum accepted pulse width: the raw level must be steady for `DEBOUNCE_CYCLES` consecutive `sync2` samples. A level held for one cycle less produces no output change.
- Strobe width: exactly 1 cycle. The strobe is coincident with the first cycle in which `pressed` shows the new value.
- `rst` is asserted asynchronously. Its release is assumed synchronised upstream (`greset` path).

## Structure

- Shared package `board_pkg` holds:
  - `CLK_HZ` = 100_000_000
  - `DEBOUNCE_MS_DEFAULT` = 10
  - derived default `DEBOUNCE_CYCLES`
- The `button` consumer and other board-level blocks reuse these constants.
- Sub-module `debounce_channel`: one synchroniser, counter and strobe generator, with ports `clk`, `rst`, `raw`, `level`, `rise`, `fall`. `button_debounce` instantiates it `N_BUTTONS` times in a generate loop.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=16, `ACTIVE_LOW`=1, `N_BUTTONS`=2, so latency is 18 cycles.

- Reset: hold `rst`=0 with `buttons`=2'b11, then release → `pressed`=00, both strobes 00 for 100 cycles.
- Clean press: drive `buttons[0]` 1→0 and hold → `press_pulse[0]` high exactly 1 cycle, 18 cycles after the first sampling edge, with `pressed[0]`=1 from that cycle. Returning to 1 gives `release_pulse[0]` 18 cycles later.
- Bounce and glitch:
  - Toggle `buttons[0]` every 5 cycles for 100 cycles, then settle at 0 → exactly one `press_pulse[0]`, 18 cycles after the final edge.
  - A 15-cycle low glitch → no output change.
- Simultaneous press: `buttons` 11→00 on one edge → `press_pulse`=2'b11 in the same single cycle, `pressed`=11. Then release only `buttons[1]` → only `release_pulse[1]` fires, and `pressed[0]` remains 1.
- Reset mid-count: press `buttons[0]`, assert `rst` asynchronously at count 10 (between clock edges), release `rst` while the button is held → outputs 0 immediately at assertion; `press_pulse[0]` fires 18 cycles after the first post-reset sampling edge.
